// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } phase_t;

  localparam int WIN_SCORE_DEF    = 5;
  localparam int SERVE_FRAMES_DEF = 120;
  localparam int HOLD_FRAMES_DEF  = 60;

  // Frame counter width, never below one bit.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= btn;
      rise <= btn & ~prev;
    end
  end

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: game phase FSM, frame counter and scores.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = WIN_SCORE_DEF,
  parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
  parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [2:0]         phase,
  output logic               game_over,
  output logic               winner
);

  localparam int CW = cnt_w(SERVE_FRAMES, HOLD_FRAMES);
  localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  phase_t        state;
  logic [CW-1:0] cnt;
  logic          start_rise;
  logic          pause_rise;

  btn_edge u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .rise  (start_rise)
  );

  btn_edge u_pause (
    .clk   (clk),
    .reset (reset),
    .btn   (pause_btn),
    .rise  (pause_rise)
  );

  assign phase = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ball_run    <= 1'b0;
      ball_center <= 1'b0;
      serve_dir   <= 1'b1;
      score_l     <= '0;
      score_r     <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      ball_center <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_rise) begin
            state       <= SERVE;
            ball_center <= 1'b1;
            serve_dir   <= 1'b1;
            cnt         <= SERVE_LD;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            if (cnt == '0) begin
              state    <= PLAY;
              ball_run <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        PLAY: begin
          // goal_right outranks goal_left; any goal outranks pause
          if (goal_right) begin
            score_l   <= score_l + 1'b1;
            serve_dir <= 1'b0;
            state     <= POINT;
            ball_run  <= 1'b0;
            cnt       <= HOLD_LD;
          end else if (goal_left) begin
            score_r   <= score_r + 1'b1;
            serve_dir <= 1'b1;
            state     <= POINT;
            ball_run  <= 1'b0;
            cnt       <= HOLD_LD;
          end else if (pause_rise) begin
            state    <= PAUSE;
            ball_run <= 1'b0;
          end
        end
        POINT: begin
          if (score_l == WIN || score_r == WIN) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= (score_r == WIN);
          end else if (frame_tick) begin
            if (cnt == '0) begin
              state       <= SERVE;
              ball_center <= 1'b1;
              cnt         <= SERVE_LD;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        PAUSE: begin
          if (pause_rise) begin
            state    <= PLAY;
            ball_run <= 1'b1;
          end
        end
        OVER: begin
          if (start_rise) begin
            state       <= SERVE;
            game_over   <= 1'b0;
            score_l     <= '0;
            score_r     <= '0;
            ball_center <= 1'b1;
            serve_dir   <= 1'b1;
            cnt         <= SERVE_LD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Randomized and directed bench for pong_match_ctrl against a rule-level model.
module tb_pong_match_ctrl;

  localparam int WIN   = 3;
  localparam int SERVE = 2;
  localparam int HOLD  = 1;
  localparam int SW    = 4;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick, start_btn, pause_btn, goal_left, goal_right;
  logic ball_run, ball_center, serve_dir, game_over, winner;
  logic [SW-1:0] score_l, score_r;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  // model state: phase numbers follow the HUD encoding
  int  m_phase, m_sl, m_sr, m_left;
  bit  m_dir, m_win, m_center;
  bit  m_s_prev, m_s_pend, m_p_prev, m_p_pend;
  bit  st_l, pa_l;
  int  pulses;

  pong_match_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SERVE),
    .HOLD_FRAMES  (HOLD),
    .SCORE_W      (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .goal_left   (goal_left),
    .goal_right  (goal_right),
    .ball_run    (ball_run),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .score_l     (score_l),
    .score_r     (score_r),
    .phase       (phase),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_sl = 0; m_sr = 0; m_left = 0;
    m_dir = 1'b1; m_win = 1'b0; m_center = 1'b0;
    m_s_prev = 0; m_s_pend = 0; m_p_prev = 0; m_p_pend = 0;
  endtask

  task automatic to_serve();
    m_phase  = 1;
    m_center = 1'b1;
    m_left   = SERVE;
  endtask

  task automatic model_edge(input bit st, pa, gl, gr, ft);
    bit s_ev, p_ev;
    s_ev = m_s_pend;
    p_ev = m_p_pend;
    m_s_pend = st && !m_s_prev;
    m_p_pend = pa && !m_p_prev;
    m_s_prev = st;
    m_p_prev = pa;
    m_center = 1'b0;
    case (m_phase)
      0: if (s_ev) begin m_dir = 1'b1; to_serve(); end
      1: if (ft) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: if (gr) begin
        m_sl++; m_dir = 1'b0; m_phase = 3; m_left = HOLD;
      end else if (gl) begin
        m_sr++; m_dir = 1'b1; m_phase = 3; m_left = HOLD;
      end else if (p_ev) m_phase = 4;
      3: if (m_sl == WIN || m_sr == WIN) begin
        m_phase = 5; m_win = (m_sr == WIN);
      end else if (ft) begin
        m_left--;
        if (m_left == 0) to_serve();
      end
      4: if (p_ev) m_phase = 2;
      5: if (s_ev) begin
        m_sl = 0; m_sr = 0; m_dir = 1'b1; to_serve();
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("phase", int'(phase), m_phase);
    chk("ball_run", int'(ball_run), int'(m_phase == 2));
    chk("ball_center", int'(ball_center), int'(m_center));
    chk("serve_dir", int'(serve_dir), int'(m_dir));
    chk("score_l", int'(score_l), m_sl);
    chk("score_r", int'(score_r), m_sr);
    chk("game_over", int'(game_over), int'(m_phase == 5));
    if (m_phase == 5) chk("winner", int'(winner), int'(m_win));
  endtask

  // called just after a falling edge
  task automatic step(input bit st, pa, gl, gr, ft);
    start_btn = st; pause_btn = pa;
    goal_left = gl; goal_right = gr; frame_tick = ft;
    @(posedge clk);
    model_edge(st, pa, gl, gr, ft);
    @(negedge clk);
    compare_all();
    if (ball_center) pulses++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {frame_tick, start_btn, pause_btn, goal_left, goal_right} = '0;
    model_reset();
    #12;
    compare_all();
    chk("rst_serve_dir", int'(serve_dir), 1);
    @(negedge clk);
    reset = 1'b0;

    // start held high: one centre pulse, then two ticks to play
    pulses = 0;
    repeat (10) step(1, 0, 0, 0, 0);
    chk("t1_pulses", pulses, 1);
    chk("t1_phase", int'(phase), 1);
    step(0, 0, 0, 0, 1);
    chk("t1_serve1", int'(phase), 1);
    step(0, 0, 0, 0, 1);
    chk("t1_play", int'(phase), 2);
    chk("t1_run", int'(ball_run), 1);

    // left player scores, hold one tick, re-serve
    step(0, 0, 0, 1, 0);
    chk("t2_score_l", int'(score_l), 1);
    chk("t2_dir", int'(serve_dir), 0);
    chk("t2_point", int'(phase), 3);
    step(0, 0, 0, 0, 1);
    chk("t2_center", int'(ball_center), 1);
    chk("t2_serve", int'(phase), 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // pause ignores goals and ticks
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t3_pause", int'(phase), 4);
    repeat (3) step(0, 0, 1, 0, 1);
    chk("t3_score_r", int'(score_r), 0);
    chk("t3_run", int'(ball_run), 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("t3_resume", int'(phase), 2);

    // right player wins 3-1
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 1, 0, 0);
      if (g < 2) begin
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
      end
    end
    step(0, 0, 0, 0, 0);
    chk("t4_over", int'(phase), 5);
    chk("t4_score_r", int'(score_r), 3);
    chk("t4_winner", int'(winner), 1);
    step(0, 0, 1, 1, 1);
    chk("t4_ignore", int'(score_l), 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("t4_restart", int'(phase), 1);
    chk("t4_clear", int'(score_l) + int'(score_r), 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // simultaneous goals: goal_right wins
    step(0, 0, 1, 1, 0);
    chk("t5_score_l", int'(score_l), 1);
    chk("t5_score_r", int'(score_r), 0);
    chk("t5_dir", int'(serve_dir), 0);

    // reset mid-hold, then nothing moves without start
    do_reset();
    chk("t6_phase", int'(phase), 0);
    repeat (5) step(0, 1, 1, 1, 1);
    chk("t6_idle", int'(phase), 0);
    step(0, 0, 0, 0, 0);

    // random play
    st_l = 0; pa_l = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 5) == 0) st_l = ~st_l;
      if ($urandom_range(0, 11) == 0) pa_l = ~pa_l;
      step(st_l, pa_l,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
